// File: rtl/egg_timer_pkg.sv
// egg_timer_pkg: shared state encoding and BCD limits for the egg timer
package egg_timer_pkg;
  typedef enum logic [1:0] {SET = 2'd0, RUN = 2'd1, PAUSE = 2'd2, ALARM = 2'd3} state_t;
  localparam logic [3:0] DIGIT_MAX = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
endpackage

// File: rtl/egg_timer_if.sv
// egg_timer_if: tick/button inputs and MM:SS display/status outputs of the countdown core
interface egg_timer_if;
  logic tick_1Hz, btn_start, btn_min, btn_sec, btn_clear;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic running, alarm;
  modport master (output tick_1Hz, btn_start, btn_min, btn_sec, btn_clear,
                  input min_tens, min_ones, sec_tens, sec_ones, running, alarm);
  modport slave (input tick_1Hz, btn_start, btn_min, btn_sec, btn_clear,
                 output min_tens, min_ones, sec_tens, sec_ones, running, alarm);
endinterface

// File: rtl/egg_timer_edge_rise.sv
// edge_rise: registered one-cycle pulse per rising edge of a level input
module edge_rise (
  input  logic CLK100Mhz,
  input  logic reset,
  input  logic d,
  output logic pulse
);
  logic d_q, armed;
  // armed stays low for the first cycle after reset so a level already high at release is not an edge
  always_ff @(posedge CLK100Mhz) begin
    if (reset) begin
      d_q <= 1'b0;
      armed <= 1'b0;
      pulse <= 1'b0;
    end else begin
      d_q <= d;
      armed <= 1'b1;
      pulse <= d & ~d_q & armed;
    end
  end
endmodule

// File: rtl/egg_timer_ctrl.sv
// egg_timer_ctrl: set/run/pause/alarm countdown core with BCD MM:SS arithmetic
module egg_timer_ctrl
  import egg_timer_pkg::*;
#(
  parameter int ALARM_SECS = 10,
  parameter int MAX_MIN = 99
) (
  input logic CLK100Mhz,
  input logic reset,
  egg_timer_if.slave bus
);
  localparam int CW = $clog2(ALARM_SECS + 1);
  localparam logic [CW-1:0] ALARM_CNT = CW'(ALARM_SECS);
  localparam logic [3:0] MT_MAX = 4'(MAX_MIN / 10);
  localparam logic [3:0] MO_MAX = 4'(MAX_MIN % 10);
  state_t state, nxt;
  logic [3:0] mt, mo, st, so, mt_n, mo_n, st_n, so_n;
  logic [3:0] si_o, si_t, mi_o, mi_t, sd_o, sd_t, md_o, md_t;
  logic [CW-1:0] cnt, cnt_n;
  logic [4:0] raw, ev;
  logic tick_ev, start_ev, min_ev, sec_ev, clr_ev;
  logic b0, b1, b2, min_top, dec_zero, nz;
  assign raw = {bus.tick_1Hz, bus.btn_start, bus.btn_min, bus.btn_sec, bus.btn_clear};
  assign {tick_ev, start_ev, min_ev, sec_ev, clr_ev} = ev;
  for (genvar i = 0; i < 5; i++) begin : g_edge
    edge_rise u_edge (.CLK100Mhz(CLK100Mhz), .reset(reset), .d(raw[i]), .pulse(ev[i]));
  end
  assign si_o = so == DIGIT_MAX ? 4'd0 : so + 4'd1;
  assign si_t = so != DIGIT_MAX ? st : st == SEC_TENS_MAX ? 4'd0 : st + 4'd1;
  assign min_top = mt == MT_MAX && mo == MO_MAX;
  assign mi_o = (min_top || mo == DIGIT_MAX) ? 4'd0 : mo + 4'd1;
  assign mi_t = min_top ? 4'd0 : mo == DIGIT_MAX ? mt + 4'd1 : mt;
  // borrow chain: each stage borrows only when every lower stage wrapped
  assign b0 = so == 4'd0;
  assign b1 = b0 && st == 4'd0;
  assign b2 = b1 && mo == 4'd0;
  assign sd_o = b0 ? DIGIT_MAX : so - 4'd1;
  assign sd_t = !b0 ? st : b1 ? SEC_TENS_MAX : st - 4'd1;
  assign md_o = !b1 ? mo : b2 ? DIGIT_MAX : mo - 4'd1;
  assign md_t = b2 ? mt - 4'd1 : mt;
  assign dec_zero = {md_t, md_o, sd_t, sd_o} == 16'd0;
  assign nz = {mt, mo, st, so} != 16'd0;
  always_comb begin
    nxt = state;
    {mt_n, mo_n, st_n, so_n} = {mt, mo, st, so};
    cnt_n = cnt;
    if (clr_ev) begin
      nxt = SET;
      {mt_n, mo_n, st_n, so_n} = '0;
      cnt_n = '0;
    end else begin
      case (state)
        SET: begin
          if (start_ev && nz) nxt = RUN;
          else begin
            if (min_ev) {mt_n, mo_n} = {mi_t, mi_o};
            if (sec_ev) {st_n, so_n} = {si_t, si_o};
          end
        end
        RUN: begin
          if (start_ev) nxt = PAUSE;
          else if (tick_ev) begin
            {mt_n, mo_n, st_n, so_n} = {md_t, md_o, sd_t, sd_o};
            if (dec_zero) nxt = ALARM;
          end
        end
        PAUSE: if (start_ev) nxt = RUN;
        ALARM: begin
          if (start_ev) begin
            nxt = SET;
            cnt_n = '0;
          end else if (tick_ev) begin
            cnt_n = cnt + 1'b1;
            if (cnt_n == ALARM_CNT) begin
              nxt = SET;
              cnt_n = '0;
            end
          end
        end
        default: nxt = SET;
      endcase
    end
  end
  always_ff @(posedge CLK100Mhz) begin
    if (reset) begin
      state <= SET;
      {mt, mo, st, so} <= '0;
      cnt <= '0;
    end else begin
      state <= nxt;
      {mt, mo, st, so} <= {mt_n, mo_n, st_n, so_n};
      cnt <= cnt_n;
    end
  end
  assign bus.min_tens = mt;
  assign bus.min_ones = mo;
  assign bus.sec_tens = st;
  assign bus.sec_ones = so;
  assign bus.running = state == RUN;
  assign bus.alarm = state == ALARM;
endmodule

// File: tb/tb_egg_timer_ctrl.sv
// tb_egg_timer_ctrl: directed stimulus with a queued-expectation scoreboard checked by a monitor
`timescale 1ns/1ps
module tb_egg_timer_ctrl;
  localparam logic [4:0] TICK = 5'b10000, START = 5'b01000, MIN = 5'b00100, SEC = 5'b00010, CLR = 5'b00001;
  typedef struct {
    string name;
    logic [15:0] d;
    logic r;
    logic a;
  } exp_t;
  logic CLK100Mhz = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  exp_t q[$];
  egg_timer_if bus ();
  egg_timer_ctrl #(.ALARM_SECS(10), .MAX_MIN(99)) dut (.CLK100Mhz(CLK100Mhz), .reset(reset), .bus(bus));
  always #5 CLK100Mhz = ~CLK100Mhz;
  always @(negedge CLK100Mhz) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [15:0] act;
      e = q.pop_front();
      act = {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones};
      checks++;
      if (act !== e.d || bus.running !== e.r || bus.alarm !== e.a) begin
        failures++;
        $display("FAIL %s: got digits=%h running=%b alarm=%b, want digits=%h running=%b alarm=%b",
                 e.name, act, bus.running, bus.alarm, e.d, e.r, e.a);
      end
    end
  end
  task automatic drive(input logic [4:0] m);
    {bus.tick_1Hz, bus.btn_start, bus.btn_min, bus.btn_sec, bus.btn_clear} = m;
  endtask
  task automatic press(input logic [4:0] m, input int hold);
    drive(m);
    repeat (hold) @(posedge CLK100Mhz);
    #1 drive(5'b0);
    repeat (3) @(posedge CLK100Mhz);
    #1;
  endtask
  task automatic expect_out(input string n, input logic [15:0] d, input logic r, input logic a);
    q.push_back('{n, d, r, a});
    @(negedge CLK100Mhz);
    #1;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
  initial begin
    drive(5'b0);
    repeat (4) @(posedge CLK100Mhz);
    expect_out("reset", 16'h0000, 1'b0, 1'b0);
    #1 reset = 1'b0;
    repeat (3) @(posedge CLK100Mhz);
    #1;
    repeat (3) press(SEC, 1);
    press(MIN, 1);
    expect_out("set_0103", 16'h0103, 1'b0, 1'b0);
    press(CLR, 1);
    press(MIN, 1);
    press(START, 1);
    expect_out("run_0100", 16'h0100, 1'b1, 1'b0);
    @(posedge CLK100Mhz);
    #1 drive(TICK);
    @(posedge CLK100Mhz);
    #1;
    expect_out("tick_lat1", 16'h0100, 1'b1, 1'b0);
    @(posedge CLK100Mhz);
    #1;
    expect_out("tick_lat2", 16'h0059, 1'b1, 1'b0);
    repeat (18) @(posedge CLK100Mhz);
    #1 drive(5'b0);
    repeat (3) @(posedge CLK100Mhz);
    #1;
    expect_out("tick_held", 16'h0059, 1'b1, 1'b0);
    press(CLR, 1);
    repeat (2) press(SEC, 1);
    press(START, 1);
    press(TICK, 1);
    expect_out("run_0001", 16'h0001, 1'b1, 1'b0);
    press(TICK, 1);
    expect_out("alarm_on", 16'h0000, 1'b0, 1'b1);
    repeat (9) press(TICK, 1);
    expect_out("alarm_9", 16'h0000, 1'b0, 1'b1);
    press(TICK, 1);
    expect_out("alarm_done", 16'h0000, 1'b0, 1'b0);
    press(CLR, 1);
    repeat (10) press(MIN, 1);
    press(START, 1);
    press(TICK, 1);
    expect_out("borrow_0959", 16'h0959, 1'b1, 1'b0);
    press(START, 1);
    expect_out("pause", 16'h0959, 1'b0, 1'b0);
    repeat (3) press(TICK, 1);
    expect_out("pause_hold", 16'h0959, 1'b0, 1'b0);
    press(START, 1);
    press(TICK, 1);
    expect_out("resume_0958", 16'h0958, 1'b1, 1'b0);
    press(START | TICK, 1);
    expect_out("start_tick", 16'h0958, 1'b0, 1'b0);
    press(CLR, 1);
    press(START, 1);
    expect_out("start_zero", 16'h0000, 1'b0, 1'b0);
    press(MIN, 1);
    for (int i = 0; i < 59; i++) press(SEC, 1);
    expect_out("sec_59", 16'h0159, 1'b0, 1'b0);
    press(SEC, 1);
    expect_out("sec_wrap", 16'h0100, 1'b0, 1'b0);
    repeat (5) press(SEC, 1);
    for (int i = 0; i < 98; i++) press(MIN, 1);
    expect_out("min_99", 16'h9905, 1'b0, 1'b0);
    press(MIN, 1);
    expect_out("min_wrap", 16'h0005, 1'b0, 1'b0);
    press(MIN | SEC, 1);
    expect_out("min_sec", 16'h0106, 1'b0, 1'b0);
    press(CLR, 1);
    repeat (5) press(MIN, 1);
    repeat (30) press(SEC, 1);
    press(START, 1);
    expect_out("run_0530", 16'h0530, 1'b1, 1'b0);
    press(CLR | START, 1);
    expect_out("clr_start", 16'h0000, 1'b0, 1'b0);
    press(SEC, 1);
    press(START, 1);
    press(TICK, 1);
    expect_out("alarm_again", 16'h0000, 1'b0, 1'b1);
    @(posedge CLK100Mhz);
    #1 reset = 1'b1;
    @(posedge CLK100Mhz);
    #1;
    expect_out("rst_alarm", 16'h0000, 1'b0, 1'b0);
    reset = 1'b0;
    repeat (3) @(posedge CLK100Mhz);
    #1;
    repeat (3) press(MIN, 1);
    press(START, 1);
    expect_out("run_0300", 16'h0300, 1'b1, 1'b0);
    @(posedge CLK100Mhz);
    #1 reset = 1'b1;
    @(posedge CLK100Mhz);
    #1;
    expect_out("rst_run", 16'h0000, 1'b0, 1'b0);
    checks++;
    if (bus.running !== 1'b0 || bus.alarm !== 1'b0) begin
      failures++;
      $display("FAIL rst_status: running=%b alarm=%b", bus.running, bus.alarm);
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard: %0d expectations never checked", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
